// File: rtl/vec_accum.sv
// Element-wise saturating vector accumulator.
// Sums a programmable number of signed fixed-point input vectors and hands the result downstream over valid/ready.
module vec_accum #(
  parameter int ARR_WIDTH = 16,
  parameter int FXP_N     = 16,
  parameter int CNT_W     = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CNT_W-1:0]             len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ARR_WIDTH*FXP_N-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ARR_WIDTH*FXP_N-1:0]   out_data,
  output logic [ARR_WIDTH-1:0]         sat_flag,
  output logic                         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [FXP_N-1:0] LANE_MAX = {1'b0, {(FXP_N-1){1'b1}}};
  localparam logic [FXP_N-1:0] LANE_MIN = {1'b1, {(FXP_N-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating lane add; MSB of the result is the clamp indication.
  // The two top bits of the widened sum differ exactly when the true sum leaves the lane range.
  function automatic logic [FXP_N:0] sat_add(input logic [FXP_N-1:0] a, input logic [FXP_N-1:0] b);
    logic [FXP_N:0] sum;
    logic [FXP_N:0] res;
    sum = {a[FXP_N-1], a} + {b[FXP_N-1], b};
    if (sum[FXP_N] != sum[FXP_N-1]) begin
      if (sum[FXP_N]) begin
        res = {1'b1, LANE_MIN};
      end else begin
        res = {1'b1, LANE_MAX};
      end
    end else begin
      res = {1'b0, sum[FXP_N-1:0]};
    end
    return res;
  endfunction

  state_t                       r_state;
  logic [CNT_W-1:0]             r_remaining;
  logic                         r_first;
  logic [ARR_WIDTH*FXP_N-1:0]   r_acc;
  logic [ARR_WIDTH-1:0]         r_sat_flag;
  logic                         r_in_ready;
  logic                         r_out_valid;
  logic                         r_busy;

  state_t                       w_next_state;
  logic                         w_start_ok;
  logic                         w_accept;
  logic                         w_last;
  logic [CNT_W-1:0]             w_len_eff;
  logic [ARR_WIDTH*FXP_N-1:0]   w_acc_next;
  logic [ARR_WIDTH-1:0]         w_sat_next;
  logic [FXP_N:0]               w_lane;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_accept   = in_valid && r_in_ready;
  assign w_last     = w_accept && (r_remaining == CNT_ONE);
  assign w_len_eff  = (len == {CNT_W{1'b0}}) ? CNT_ONE : len;

  // Next-state selection for the IDLE/ACCUM/DRAIN sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_ACCUM;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (w_last) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_ACCUM;
        end
      end
      S_DRAIN: begin
        if (r_out_valid && out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DRAIN;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Per-lane accumulate datapath; the first beat loads without adding.
  always_comb begin
    w_acc_next = r_acc;
    w_sat_next = r_sat_flag;
    w_lane     = {(FXP_N+1){1'b0}};
    for (int i = 0; i < ARR_WIDTH; i++) begin
      w_lane = sat_add(r_acc[i*FXP_N +: FXP_N], in_data[i*FXP_N +: FXP_N]);
      if (r_first) begin
        w_acc_next[i*FXP_N +: FXP_N] = in_data[i*FXP_N +: FXP_N];
      end else begin
        w_acc_next[i*FXP_N +: FXP_N] = w_lane[FXP_N-1:0];
        w_sat_next[i]                = r_sat_flag[i] | w_lane[FXP_N];
      end
    end
  end

  // State register and handshake/status flops decoded from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == S_ACCUM);
      r_out_valid <= (w_next_state == S_DRAIN);
      r_busy      <= (w_next_state != S_IDLE);
    end
  end

  // Beat counter and first-beat marker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_remaining <= {CNT_W{1'b0}};
      r_first     <= 1'b0;
    end else if (w_start_ok) begin
      r_remaining <= w_len_eff;
      r_first     <= 1'b1;
    end else if (w_accept) begin
      r_remaining <= r_remaining - CNT_ONE;
      r_first     <= 1'b0;
    end
  end

  // Accumulator and sticky clamp flags; both hold after the result is taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc      <= {(ARR_WIDTH*FXP_N){1'b0}};
      r_sat_flag <= {ARR_WIDTH{1'b0}};
    end else if (w_start_ok) begin
      r_sat_flag <= {ARR_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_acc      <= w_acc_next;
      r_sat_flag <= w_sat_next;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign sat_flag  = r_sat_flag;
  assign busy      = r_busy;

endmodule

// File: tb/tb_vec_accum.sv
// Self-checking bench for vec_accum: directed cases plus randomized accumulations
// compared against an integer reference model.
module tb_vec_accum;
  localparam int AW = 16;
  localparam int FN = 16;
  localparam int CW = 8;
  localparam int DW = AW * FN;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] sat_flag;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] beats[$];

  vec_accum #(.ARR_WIDTH(AW), .FXP_N(FN), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] splat(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < AW; i++) r[i*FN +: FN] = v[FN-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] r;
    for (int w = 0; w < DW/32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  // Mix of small values and full-range values so both quiet sums and clamps occur.
  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    int v;
    for (int i = 0; i < AW; i++) begin
      if ($urandom_range(0, 1) == 0) v = $urandom_range(0, 200) - 100;
      else v = $urandom_range(0, 65535) - 32768;
      r[i*FN +: FN] = v[FN-1:0];
    end
    return r;
  endfunction

  // Reference: first beat loads, every later beat adds with clamping to the signed lane range.
  task automatic model(output logic [DW-1:0] res, output logic [AW-1:0] fl);
    int acc;
    int b;
    res = '0;
    fl  = '0;
    for (int i = 0; i < AW; i++) begin
      acc = $signed(beats[0][i*FN +: FN]);
      for (int k = 1; k < beats.size(); k++) begin
        b = $signed(beats[k][i*FN +: FN]);
        acc = acc + b;
        if (acc > 32767) begin
          acc = 32767;
          fl[i] = 1'b1;
        end else if (acc < -32768) begin
          acc = -32768;
          fl[i] = 1'b1;
        end
      end
      res[i*FN +: FN] = acc[FN-1:0];
    end
  endtask

  // vmode: 0 valid always, 1 random valid, 2 pattern 1,0,1,0,1,1,...
  task automatic run_acc(input int l, input int vmode, input int stall, input bit poke);
    logic [DW-1:0] exp_d;
    logic [AW-1:0] exp_f;
    int need, got_n, cyc;
    bit v;
    need = (l == 0) ? 1 : l;
    model(exp_d, exp_f);
    @(negedge clock);
    check_val("idle_busy", DW'(busy), DW'(0));
    check_val("idle_in_ready", DW'(in_ready), DW'(0));
    start = 1'b1;
    len = l[CW-1:0];
    in_valid = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check_val("accum_busy", DW'(busy), DW'(1));
    check_val("sat_cleared", DW'(sat_flag), DW'(0));
    got_n = 0;
    cyc = 0;
    while (got_n < need) begin
      if (cyc > 4000) begin
        check_val("beat_timeout", DW'(got_n), DW'(need));
        break;
      end
      check_val("accum_in_ready", DW'(in_ready), DW'(1));
      check_val("accum_out_valid", DW'(out_valid), DW'(0));
      case (vmode)
        0: v = 1'b1;
        1: v = $urandom_range(0, 1);
        default: v = (cyc == 1 || cyc == 3) ? 1'b0 : 1'b1;
      endcase
      in_valid = v;
      in_data = v ? beats[got_n] : rand_vec();
      start = poke && (cyc % 2 == 1);
      @(negedge clock);
      if (v) got_n++;
      cyc++;
    end
    in_valid = 1'b1;
    in_data = rand_vec();
    start = poke;
    check_val("drain_out_valid", DW'(out_valid), DW'(1));
    check_val("drain_in_ready", DW'(in_ready), DW'(0));
    check_val("drain_data", out_data, exp_d);
    check_val("drain_sat", DW'(sat_flag), DW'(exp_f));
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      check_val("stall_out_valid", DW'(out_valid), DW'(1));
      check_val("stall_data", out_data, exp_d);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check_val("post_out_valid", DW'(out_valid), DW'(0));
    check_val("post_busy", DW'(busy), DW'(0));
    check_val("post_data_hold", out_data, exp_d);
    check_val("post_sat_hold", DW'(sat_flag), DW'(exp_f));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] t;
    int l;
    #2 reset = 1'b1;
    #1;
    check_val("rst_out_valid", DW'(out_valid), DW'(0));
    check_val("rst_data", out_data, '0);
    check_val("rst_sat", DW'(sat_flag), DW'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;

    beats = {splat(1), splat(2), splat(3)};
    run_acc(3, 0, 0, 1'b0);

    t = splat(1);
    t[15:0] = 16'h7000;
    beats = {t};
    t = splat(-1);
    t[15:0] = 16'h2000;
    beats.push_back(t);
    run_acc(2, 0, 1, 1'b0);

    beats = {splat(0), splat(0), splat(0)};
    beats[0][5*FN +: FN] = 16'h8000;
    beats[1][5*FN +: FN] = 16'hFFFF;
    beats[2][5*FN +: FN] = 16'h0005;
    run_acc(3, 0, 0, 1'b0);

    beats = {rand_beat(), rand_beat(), rand_beat(), rand_beat()};
    run_acc(4, 2, 5, 1'b0);

    beats = {splat(7)};
    run_acc(0, 0, 3, 1'b1);

    // Asynchronous reset in the middle of an accumulation.
    @(negedge clock);
    start = 1'b1;
    len = 8'd4;
    @(negedge clock);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = splat(100);
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_busy", DW'(busy), DW'(0));
    check_val("mid_rst_in_ready", DW'(in_ready), DW'(0));
    check_val("mid_rst_out_valid", DW'(out_valid), DW'(0));
    check_val("mid_rst_data", out_data, '0);
    @(negedge clock);
    reset = 1'b0;
    beats = {splat(9)};
    run_acc(1, 0, 0, 1'b0);

    for (int n = 0; n < 15; n++) begin
      l = $urandom_range(0, 12);
      beats = {};
      for (int k = 0; k < ((l == 0) ? 1 : l); k++) beats.push_back(rand_beat());
      run_acc(l, $urandom_range(0, 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    beats = {};
    for (int k = 0; k < 255; k++) beats.push_back(rand_beat());
    run_acc(255, 0, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
